// File: rtl/led_show_pkg.sv
// Shared constants and helpers for the scanned LED show driver.
// Widths derived from the default configuration plus the LED pattern builder.
package led_show_pkg;

  localparam int DATA_W_DEF         = 4;
  localparam int LED_W_DEF          = 6;
  localparam int N_CH_DEF           = 4;
  localparam int TICK_DIV_DEF       = 50000;
  localparam int DWELL_DEF          = 200;
  localparam int BLINK_TICKS_DEF    = 250;
  localparam int BRIGHT_W_DEF       = 4;
  localparam int LED_ACTIVE_LOW_DEF = 1;

  // Width of a counter/index that spans n values; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] low_mask(input int w);
    if (w >= 32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'd1 << w) - 32'd1;
    end
  endfunction

  function automatic logic [31:0] led_dark(input int led_w, input bit active_low);
    return active_low ? low_mask(led_w) : 32'd0;
  endfunction

  // Channel index sits above the value; bits beyond led_w fall off, so the
  // index field is truncated or zero-extended to whatever room is left.
  function automatic logic [31:0] led_drive(input logic [31:0] ch, input logic [31:0] val,
                                            input int data_w, input int led_w,
                                            input bit active_low);
    logic [31:0] pat;
    pat = ((ch << data_w) | (val & low_mask(data_w))) & low_mask(led_w);
    if (active_low) begin
      pat = ~pat & low_mask(led_w);
    end else begin
      pat = pat;
    end
    return pat;
  endfunction

  localparam int CH_W       = ch_width(N_CH_DEF);
  localparam int CH_FIELD_W = LED_W_DEF - DATA_W_DEF;
  localparam logic [LED_W_DEF-1:0] LED_DARK =
    LED_W_DEF'(led_dark(LED_W_DEF, LED_ACTIVE_LOW_DEF != 0));

endpackage

// File: rtl/led_show_scan_tick.sv
// Generic modulo counter: counts enabled cycles 0..MOD-1 and pulses o_wrap
// on the wrap; with i_hold it saturates at MOD-1 instead of wrapping.
module led_tick_gen
  import led_show_pkg::*;
#(
  parameter int MOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_hold,
  output logic o_wrap
);

  localparam int              CW   = ch_width(MOD);
  localparam logic [CW-1:0]   LAST = CW'(MOD - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_wrap    = i_en && w_at_last && !i_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (o_wrap) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_last) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_show_scan.sv
// Round-robin multi-channel LED display with dwell, blink, PWM brightness,
// channel-index field, freeze and a valid/ready write port.
module led_show_scan
  import led_show_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int LED_W          = LED_W_DEF,
  parameter int N_CH           = N_CH_DEF,
  parameter int TICK_DIV       = TICK_DIV_DEF,
  parameter int DWELL          = DWELL_DEF,
  parameter int BLINK_TICKS    = BLINK_TICKS_DEF,
  parameter int BRIGHT_W       = BRIGHT_W_DEF,
  parameter int LED_ACTIVE_LOW = LED_ACTIVE_LOW_DEF
) (
  input  logic                         clk,
  input  logic                         sys_rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ch_width(N_CH)-1:0]    wr_ch,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_blink,
  output logic                         wr_err,
  input  logic [BRIGHT_W-1:0]          bright,
  input  logic                         freeze,
  output logic [ch_width(N_CH)-1:0]    cur_ch,
  output logic                         frame_done,
  output logic [LED_W-1:0]             led
);

  localparam int               CHW      = ch_width(N_CH);
  localparam logic [CHW:0]     N_CH_EXT = (CHW + 1)'(N_CH);
  localparam logic [CHW-1:0]   CH_LAST  = CHW'(N_CH - 1);
  localparam bit               ACT_LOW  = (LED_ACTIVE_LOW != 0);
  localparam logic [LED_W-1:0] DARK     = LED_W'(led_dark(LED_W, ACT_LOW));

  logic [N_CH-1:0][DATA_W-1:0] r_val;
  logic [N_CH-1:0]             r_blink;
  logic [CHW-1:0]              r_cur_ch;
  logic                        r_phase;
  logic [BRIGHT_W-1:0]         r_pwm_cnt;
  logic                        r_wr_ready;
  logic                        r_wr_err;
  logic                        r_frame_done;
  logic [LED_W-1:0]            r_led;

  logic             w_tick;
  logic             w_advance;
  logic             w_blink_wrap;
  logic             w_accept;
  logic             w_in_range;
  logic             w_pwm_on;
  logic             w_visible;
  logic [LED_W-1:0] w_lit;

  led_tick_gen #(.MOD(TICK_DIV)) u_prescale (
    .clk(clk), .rst(sys_rst), .i_en(1'b1), .i_hold(1'b0), .o_wrap(w_tick)
  );

  // Dwell saturates under freeze so the advance fires on the first tick after release.
  led_tick_gen #(.MOD(DWELL)) u_dwell (
    .clk(clk), .rst(sys_rst), .i_en(w_tick), .i_hold(freeze), .o_wrap(w_advance)
  );

  led_tick_gen #(.MOD(BLINK_TICKS)) u_blink (
    .clk(clk), .rst(sys_rst), .i_en(w_tick), .i_hold(1'b0), .o_wrap(w_blink_wrap)
  );

  assign w_accept   = wr_valid && r_wr_ready;
  assign w_in_range = ({1'b0, wr_ch} < N_CH_EXT);

  always_comb begin
    w_pwm_on  = (r_pwm_cnt < bright) || (&bright);
    w_visible = w_pwm_on && !(r_blink[r_cur_ch] && r_phase);
    w_lit     = LED_W'(led_drive(32'(r_cur_ch), 32'(r_val[r_cur_ch]), DATA_W, LED_W, ACT_LOW));
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_val      <= '0;
      r_blink    <= '0;
      r_wr_ready <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_wr_ready <= 1'b1;
      r_wr_err   <= w_accept && !w_in_range;
      if (w_accept && w_in_range) begin
        r_val[wr_ch]   <= wr_data;
        r_blink[wr_ch] <= wr_blink;
      end
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cur_ch     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_advance && (r_cur_ch == CH_LAST);
      if (w_advance) begin
        r_cur_ch <= (r_cur_ch == CH_LAST) ? '0 : r_cur_ch + CHW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_phase   <= 1'b0;
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + BRIGHT_W'(1);
      if (w_blink_wrap) begin
        r_phase <= ~r_phase;
      end
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_led <= DARK;
    end else begin
      r_led <= w_visible ? w_lit : DARK;
    end
  end

  assign wr_ready   = r_wr_ready;
  assign wr_err     = r_wr_err;
  assign cur_ch     = r_cur_ch;
  assign frame_done = r_frame_done;
  assign led        = r_led;

endmodule

// File: tb/tb_led_show_scan.sv
// Scoreboard bench for led_show_scan: a behavioural model pushes expected
// outputs each cycle, popped and compared once the DUT edge has happened.
module tb_led_show_scan;

  localparam int DATA_W      = 4;
  localparam int LED_W       = 6;
  localparam int N_CH        = 4;
  localparam int TICK_DIV    = 4;
  localparam int DWELL       = 2;
  localparam int BLINK_TICKS = 3;
  localparam int BRIGHT_W    = 4;

  logic              clk = 1'b0;
  logic              sys_rst;
  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        wr_ch;
  logic [DATA_W-1:0] wr_data;
  logic              wr_blink;
  logic              wr_err;
  logic [3:0]        bright;
  logic              freeze;
  logic [1:0]        cur_ch;
  logic              frame_done;
  logic [LED_W-1:0]  led;

  always #5 clk = ~clk;

  led_show_scan #(
    .DATA_W(DATA_W), .LED_W(LED_W), .N_CH(N_CH), .TICK_DIV(TICK_DIV),
    .DWELL(DWELL), .BLINK_TICKS(BLINK_TICKS), .BRIGHT_W(BRIGHT_W), .LED_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_data(wr_data), .wr_blink(wr_blink), .wr_err(wr_err),
    .bright(bright), .freeze(freeze), .cur_ch(cur_ch), .frame_done(frame_done),
    .led(led)
  );

  typedef struct packed {
    logic [5:0] led;
    logic [1:0] cur;
    logic       fd;
    logic       rdy;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fd_seen  = 0;
  int   n_watch  = 0;
  int   n_dark   = 0;
  logic [5:0] watch_val = 6'h00;

  int         m_pre, m_dwell, m_bc;
  logic [1:0] m_cur;
  logic [3:0] m_pwm;
  logic       m_phase, m_ready;
  logic [3:0] m_val [4];
  logic       m_blink [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_dwell = 0; m_bc = 0; m_cur = 2'd0; m_pwm = 4'd0;
    m_phase = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 4'h0; m_blink[i] = 1'b0;
    end
  endtask

  function automatic logic [5:0] model_led();
    logic [5:0] lit;
    logic       vis;
    lit = {m_cur, m_val[m_cur]};
    vis = ((m_pwm < bright) || (bright == 4'hF)) && !(m_blink[m_cur] && m_phase);
    return vis ? ~lit : 6'b111111;
  endfunction

  // One clock: predict the post-edge outputs, advance the model, then compare.
  task automatic cycle();
    exp_t e;
    logic tick, adv;
    e.led = model_led();
    tick  = (m_pre == TICK_DIV - 1);
    adv   = tick && (m_dwell == DWELL - 1) && !freeze;
    e.fd  = adv && (m_cur == 2'd3);
    e.err = wr_valid && m_ready && (int'(wr_ch) >= N_CH);
    if (wr_valid && m_ready && (int'(wr_ch) < N_CH)) begin
      m_val[wr_ch]   = wr_data;
      m_blink[wr_ch] = wr_blink;
    end
    m_pre = (m_pre + 1) % TICK_DIV;
    if (tick) begin
      if (m_dwell == DWELL - 1) begin
        if (!freeze) begin
          m_dwell = 0;
          m_cur   = m_cur + 2'd1;
        end
      end else begin
        m_dwell++;
      end
      if (m_bc == BLINK_TICKS - 1) begin
        m_bc    = 0;
        m_phase = ~m_phase;
      end else begin
        m_bc++;
      end
    end
    m_pwm   = m_pwm + 4'd1;
    m_ready = 1'b1;
    e.cur   = m_cur;
    e.rdy   = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check_eq("led", led, e.led);
    check_eq("cur_ch", cur_ch, e.cur);
    check_eq("frame_done", frame_done, e.fd);
    check_eq("wr_ready", wr_ready, e.rdy);
    check_eq("wr_err", wr_err, e.err);
    if (frame_done) fd_seen++;
    if (led == watch_val) n_watch++;
    if (led == 6'b111111) n_dark++;
  endtask

  task automatic run_until(input logic [1:0] target, input int budget);
    int n;
    n = 0;
    while (m_cur != target && n < budget) begin
      cycle();
      n++;
    end
    check_eq("reach_ch", cur_ch, target);
  endtask

  task automatic write(input logic [1:0] ch, input logic [3:0] d, input logic b);
    wr_valid = 1'b1; wr_ch = ch; wr_data = d; wr_blink = b;
    cycle();
    wr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic found;
    sys_rst = 1'b1; wr_valid = 1'b0; wr_ch = 2'd0; wr_data = 4'h0; wr_blink = 1'b0;
    bright = 4'hF; freeze = 1'b0;
    model_reset();
    #1;
    check_eq("rst_led", led, 6'b111111);
    check_eq("rst_cur", cur_ch, 2'd0);
    check_eq("rst_rdy", wr_ready, 1'b0);
    check_eq("rst_fd", frame_done, 1'b0);
    check_eq("rst_err", wr_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    sys_rst = 1'b0;

    // Idle scan: two full frames in 64 clocks.
    fd_seen = 0;
    repeat (64) cycle();
    check_eq("frame_count", fd_seen, 2);

    write(2'd2, 4'hA, 1'b0);
    run_until(2'd2, 64);
    cycle();
    check_eq("ch2_led", led, 6'b010101);

    // Blink on frozen ch1: 12 clocks lit, 12 dark.
    write(2'd1, 4'h5, 1'b1);
    run_until(2'd1, 64);
    freeze = 1'b1;
    repeat (2) cycle();
    watch_val = 6'b101010; n_watch = 0; n_dark = 0;
    repeat (48) cycle();
    check_eq("blink_lit", n_watch, 24);
    check_eq("blink_dark", n_dark, 24);
    check_eq("freeze_cur", cur_ch, 2'd1);
    freeze = 1'b0;

    // PWM on ch3 = F.
    write(2'd3, 4'hF, 1'b0);
    run_until(2'd3, 64);
    freeze = 1'b1; bright = 4'h4;
    repeat (2) cycle();
    watch_val = 6'b000000; n_watch = 0; n_dark = 0;
    repeat (16) cycle();
    check_eq("pwm4_lit", n_watch, 4);
    check_eq("pwm4_dark", n_dark, 12);
    bright = 4'h0;
    n_watch = 0; n_dark = 0;
    repeat (16) cycle();
    check_eq("pwm0_dark", n_dark, 16);
    check_eq("pwm0_lit", n_watch, 0);
    bright = 4'hF; freeze = 1'b0;

    // Write ch0 on the same edge as the 3 -> 0 wrap.
    n = 0;
    found = (m_cur == 2'd3 && m_pre == TICK_DIV - 1 && m_dwell == DWELL - 1);
    while (!found && n < 64) begin
      cycle();
      n++;
      found = (m_cur == 2'd3 && m_pre == TICK_DIV - 1 && m_dwell == DWELL - 1);
    end
    check_eq("wrap_found", found, 1'b1);
    write(2'd0, 4'h7, 1'b0);
    check_eq("wrap_fd", frame_done, 1'b1);
    check_eq("wrap_cur", cur_ch, 2'd0);
    cycle();
    check_eq("wrap_led", led, 6'b111000);

    // Asynchronous reset mid-dwell on ch2.
    run_until(2'd2, 64);
    cycle();
    #2;
    sys_rst = 1'b1;
    #1;
    check_eq("arst_led", led, 6'b111111);
    check_eq("arst_cur", cur_ch, 2'd0);
    check_eq("arst_rdy", wr_ready, 1'b0);
    model_reset();
    @(negedge clk);
    sys_rst = 1'b0;
    run_until(2'd1, 64);
    cycle();
    check_eq("post_rst_ch1", led, 6'b101111);
    run_until(2'd2, 64);
    cycle();
    check_eq("post_rst_ch2", led, 6'b011111);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_show_scan.md
Name: led_show_scan

Overview:
- Parametrised successor to the single-nibble LED display driver.
- Holds N_CH channel values and shows them round-robin on one LED bank. Each channel stays on for a programmable dwell time.
- Adds per-channel blink, global PWM brightness, a channel-index field on the upper LEDs and a freeze control.
- Sits between the keypad/data decoder and the board LED pins. Channel values are written through a valid/ready port.

Parameters:
- DATA_W, 4: bits per channel value.
- LED_W, 6: LED bank width. Must be >= DATA_W. The upper LED_W-DATA_W bits show the channel index, truncated or zero-extended to fit.
- N_CH, 4: number of channels. Must be >= 2.
- TICK_DIV, 50000: clk cycles per display tick. Must be >= 1.
- DWELL, 200: ticks each channel is displayed. Must be >= 1.
- BLINK_TICKS, 250: ticks per blink half-period. Must be >= 1.
- BRIGHT_W, 4: brightness/PWM counter width.
- LED_ACTIVE_LOW, 1: 1 means a 0 drives an LED lit (common anode).

Ports:
- clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when high together with wr_valid
- wr_ch  in  clog2(N_CH)  target channel
- wr_data  in  DATA_W  channel value
- wr_blink  in  1  blink enable for the target channel
- wr_err  out  1  one-cycle pulse when a write names an out-of-range channel
- bright  in  BRIGHT_W  global brightness level
- freeze  in  1  hold the current channel, no advance
- cur_ch  out  clog2(N_CH)  channel currently displayed
- frame_done  out  1  one-cycle pulse when the scan wraps from channel N_CH-1 to 0
- led  out  LED_W  LED drive, registered

Behaviour:
- Reset (async assert, sync release):
  - All channel values 0, blink bits 0.
  - All counters 0; cur_ch=0; blink phase=0.
  - wr_ready=0, wr_err=0, frame_done=0.
  - led = all dark: all 1s if LED_ACTIVE_LOW, all 0s otherwise.
  - Reset mid-scan or mid-write discards everything.
- wr_ready is a registered 1 from the first clk edge after reset release onward.
- Write handshake:
  - A write is accepted on an edge where wr_valid && wr_ready.
  - If wr_ch < N_CH: the channel value and blink bit are updated at that edge.
  - If wr_ch >= N_CH (possible only when N_CH is not a power of two): no update, wr_err pulses for the next cycle.
- Tick prescaler: counts 0..TICK_DIV-1 and issues a one-cycle tick on wrap.
- Dwell counter:
  - Counts ticks. When it reaches DWELL-1 and freeze=0, the tick advances cur_ch and clears the dwell counter.
  - cur_ch wraps N_CH-1 -> 0; frame_done pulses on the same edge as that wrap.
  - With freeze=1 the dwell counter saturates at DWELL-1; cur_ch advances on the first tick after freeze drops.
- Blink: phase toggles every BLINK_TICKS ticks, independent of freeze.
- PWM:
  - Free-running BRIGHT_W-bit counter on clk.
  - pwm_on = (pwm_cnt < bright) OR (bright == all-ones).
  - bright=0 means always dark.
- Lit pattern: {cur_ch field, value[cur_ch]}.
- Visible = pwm_on AND NOT (blink[cur_ch] AND phase).
- led register each cycle:
  - visible: lit pattern, inverted if LED_ACTIVE_LOW;
  - not visible: all dark.
- Latency:
  - led updates at the edge after any state change (write, channel advance, phase toggle): 1 cycle.
  - A write to the displayed channel appears on led at the edge after it is accepted.
- Simultaneous write and advance on the same edge: the write lands in its target register; led then shows the new cur_ch using the post-write values.

Decomposition:
- Shared package led_show_pkg holds:
  - derived width constants: CH_W = clog2(N_CH), CH_FIELD_W = LED_W - DATA_W;
  - a function that builds the lit pattern and applies polarity;
  - the LED_DARK constant.
- One sub-module is natural: led_tick_gen, the prescaler plus a generic modulo tick counter.
  - It is instanced for the tick, dwell and blink counters.

Test Plan:
- Setup: N_CH=4, TICK_DIV=4, DWELL=2, BLINK_TICKS=3, BRIGHT_W=4, LED_ACTIVE_LOW=1, LED_W=6, DATA_W=4.
- Reset then release, bright=4'hF, no writes -> led=6'b111111 during reset; after release cur_ch steps 0,1,2,3,0 every 8 clk; frame_done pulses once per 32 clk.
- Write ch2=4'hA, no blink; bright=4'hF -> while cur_ch=2, led = ~{2'b10,4'b1010} = 6'b010101.
- Write ch1=4'h5 with blink=1, freeze=1 held at ch1 -> led alternates ~{01,0101}=6'b101010 and 6'b111111 every 12 clk; cur_ch stays 1.
- bright=4'h4 on ch3 with value 4'hF -> led lit for 4 of every 16 clk and dark for 12, repeating; bright=0 -> led constant 6'b111111.
- Write with wr_ch=ch0 in the same cycle cur_ch advances 3->0 -> frame_done=1; led shows the new ch0 value one edge later.
- Assert sys_rst mid-dwell on ch2 -> led=6'b111111 and cur_ch=0 immediately (async); all values read 0 afterwards.
